fighting_arena: RTL

Parametrised successor of the two-player fighting game top. It holds both fighters' positions, lives, attack cooldowns and a round timer in one synchronous block, and declares a winner. A `control` tick-enable advances the game instead of gating the clock. It sits between the per-player action decoders and the display/score logic.

---
 rtl/fighting_arena.sv | 139 +++++++++++++
 1 files changed

// File: rtl/fighting_arena.sv
// Two-player fighting arena: positions, lives, attack cooldowns and round timer.
// Optional macro FIGHT_KNOCKBACK_EN pushes a single-hit target one cell away from the attacker.
module fighting_arena #(
  parameter int POS_W      = 2,
  parameter int LIFE_W     = 2,
  parameter int MAX_LIVES  = 3,
  parameter int COOLDOWN   = 2,
  parameter int TIMER_W    = 8,
  parameter int TIME_LIMIT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         action1,
  input  logic [2:0]         action2,
  input  logic               control,
  output logic [POS_W-1:0]   place1,
  output logic [POS_W-1:0]   place2,
  output logic [LIFE_W-1:0]  lives1,
  output logic [LIFE_W-1:0]  lives2,
  output logic [TIMER_W-1:0] timer,
  output logic               game_over,
  output logic [1:0]         winner
);

  localparam int CD_W = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
  localparam logic [POS_W-1:0]   MAX_POS    = {POS_W{1'b1}};
  localparam logic [POS_W-1:0]   POS_ONE    = POS_W'(1);
  localparam logic [POS_W-1:0]   POS_TWO    = POS_W'(2);
  localparam logic [CD_W-1:0]    CD_LOAD    = CD_W'(COOLDOWN);
  localparam logic [CD_W-1:0]    CD_ONE     = CD_W'(1);
  localparam logic [LIFE_W-1:0]  LIVES_INIT = LIFE_W'(MAX_LIVES);
  localparam logic [TIMER_W-1:0] TIMER_INIT = TIMER_W'(TIME_LIMIT);
  localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);

  localparam logic [2:0] ACT_LEFT   = 3'b001;
  localparam logic [2:0] ACT_RIGHT  = 3'b010;
  localparam logic [2:0] ACT_ATTACK = 3'b011;
  localparam logic [2:0] ACT_DEFEND = 3'b100;

  typedef enum logic {FIGHT, OVER} state_t;

  state_t              state, state_nx;
  logic [CD_W-1:0]     cd1, cd2, cd1_nx, cd2_nx;
  logic [POS_W-1:0]    place1_nx, place2_nx, gap;
  logic [LIFE_W-1:0]   lives1_nx, lives2_nx;
  logic [TIMER_W-1:0]  timer_nx;
  logic [1:0]          winner_nx;
  logic                left1, right1, atk1, def1, left2, right2, atk2, def2;
  logic                hit1, hit2;

  function automatic logic [LIFE_W-1:0] lose_life(input logic [LIFE_W-1:0] l);
    return (l == '0) ? l : l - LIFE_W'(1);
  endfunction

  function automatic logic [CD_W-1:0] cool_down(input logic [CD_W-1:0] c);
    return (c == '0) ? c : c - CD_ONE;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= FIGHT;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    place1_nx = place1;
    place2_nx = place2;
    lives1_nx = lives1;
    lives2_nx = lives2;
    timer_nx  = timer;
    cd1_nx    = cd1;
    cd2_nx    = cd2;
    winner_nx = winner;
    gap       = place2 - place1;
    left1     = (action1 == ACT_LEFT);
    right1    = (action1 == ACT_RIGHT);
    def1      = (action1 == ACT_DEFEND);
    atk1      = (action1 == ACT_ATTACK) && (cd1 == '0);
    left2     = (action2 == ACT_LEFT);
    right2    = (action2 == ACT_RIGHT);
    def2      = (action2 == ACT_DEFEND);
    atk2      = (action2 == ACT_ATTACK) && (cd2 == '0);
    hit2      = atk1 && (gap == POS_ONE) && !def2;
    hit1      = atk2 && (gap == POS_ONE) && !def1;

    if (state == FIGHT && control) begin
      // Moves: converging at gap 2 blocks both so they never share a cell.
      if (left1 && place1 != '0) place1_nx = place1 - POS_ONE;
      if (right1 && gap >= POS_TWO && !(gap == POS_TWO && left2)) place1_nx = place1 + POS_ONE;
      if (right2 && place2 != MAX_POS) place2_nx = place2 + POS_ONE;
      if (left2 && gap >= POS_TWO && !(gap == POS_TWO && right1)) place2_nx = place2 - POS_ONE;
`ifdef FIGHT_KNOCKBACK_EN
      if (hit2 && !hit1 && place2 != MAX_POS) place2_nx = place2 + POS_ONE;
      if (hit1 && !hit2 && place1 != '0)      place1_nx = place1 - POS_ONE;
`endif
      if (hit1) lives1_nx = lose_life(lives1);
      if (hit2) lives2_nx = lose_life(lives2);
      cd1_nx   = atk1 ? CD_LOAD : cool_down(cd1);
      cd2_nx   = atk2 ? CD_LOAD : cool_down(cd2);
      timer_nx = timer - TIMER_ONE;

      // Round end is judged on the post-tick lives and timer.
      if (lives1_nx == '0 || lives2_nx == '0 || timer_nx == '0) begin
        state_nx = OVER;
        if (lives1_nx == '0 && lives2_nx == '0) winner_nx = 2'b11;
        else if (lives1_nx == '0)               winner_nx = 2'b10;
        else if (lives2_nx == '0)               winner_nx = 2'b01;
        else if (lives1_nx > lives2_nx)         winner_nx = 2'b01;
        else if (lives2_nx > lives1_nx)         winner_nx = 2'b10;
        else                                    winner_nx = 2'b11;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      place1 <= '0;
      place2 <= MAX_POS;
      lives1 <= LIVES_INIT;
      lives2 <= LIVES_INIT;
      timer  <= TIMER_INIT;
      cd1    <= '0;
      cd2    <= '0;
      winner <= 2'b00;
    end else begin
      place1 <= place1_nx;
      place2 <= place2_nx;
      lives1 <= lives1_nx;
      lives2 <= lives2_nx;
      timer  <= timer_nx;
      cd1    <= cd1_nx;
      cd2    <= cd2_nx;
      winner <= winner_nx;
    end
  end

  assign game_over = (state == OVER);

endmodule
